onehot_capture: RTL

ONEHOT_CAPTURE -- requirements
Module: onehot_capture

---
 rtl/onehot_capture.sv | 123 ++++++++++++
 1 files changed

// File: rtl/onehot_capture.sv
// Button capture front end: synchronizes and debounces 8 request lines, then hands a
// single one-hot request to the encoder with a valid/ack handshake, once per press.
module onehot_capture #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] btn_in,
    input  logic       ack,
    output logic [7:0] onehot_out,
    output logic       valid,
    output logic       multi_err
);

    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        RELEASE
    } state_t;

    logic [7:0] meta_q;
    logic [7:0] sync_q;
    logic [7:0] prev_q;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] stable_q, stable_d;
    state_t     state_q, state_d;
    logic [7:0] onehot_q, onehot_d;
    logic       valid_q, valid_d;
    logic       multi_q, multi_d;
    logic [3:0] stable_ones;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // A vector is accepted only after it has sat unchanged at the synchronizer output
    // long enough for the counter to saturate.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync_q != prev_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end
        if ((sync_q == prev_q) && (cnt_q == CNT_MAX)) begin
            stable_d = sync_q;
        end
    end

    assign stable_ones = popcount8(stable_q);

    always_comb begin
        state_d  = state_q;
        onehot_d = onehot_q;
        valid_d  = valid_q;
        multi_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (stable_ones == 4'd1) begin
                    onehot_d = stable_q;
                    valid_d  = 1'b1;
                    state_d  = HOLD;
                end else if (stable_ones >= 4'd2) begin
                    multi_d = 1'b1;
                    state_d = RELEASE;
                end
            end
            HOLD: begin
                if (ack) begin
                    onehot_d = '0;
                    valid_d  = 1'b0;
                    state_d  = RELEASE;
                end
            end
            RELEASE: begin
                // Wait for all lines released so a long press yields one capture only.
                if (stable_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q   <= '0;
            sync_q   <= '0;
            prev_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
            state_q  <= IDLE;
            onehot_q <= '0;
            valid_q  <= 1'b0;
            multi_q  <= 1'b0;
        end else begin
            meta_q   <= btn_in;
            sync_q   <= meta_q;
            prev_q   <= sync_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            state_q  <= state_d;
            onehot_q <= onehot_d;
            valid_q  <= valid_d;
            multi_q  <= multi_d;
        end
    end

    assign onehot_out = onehot_q;
    assign valid      = valid_q;
    assign multi_err  = multi_q;

endmodule
